// File: rtl/mcu_icache_refill.sv
// I-cache miss-refill responder: fetches one line as pipelined in-order word reads
// from the backing memory port and returns it as a single one-cycle response pulse.
module mcu_icache_refill #(
  parameter int          LINE_BYTES    = 32,
  parameter int          MEM_DATA_BITS = 32,
  parameter logic [31:0] ERR_WORD      = 32'h0010_0073
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_req_valid,
  input  logic [31:0]                miss_req_addr,
  output logic                       miss_req_ready,
  output logic                       miss_resp_valid,
  output logic [LINE_BYTES*8-1:0]    miss_resp_data,
  output logic                       mem_req_valid,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_req_ready,
  input  logic                       mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
  input  logic                       mem_resp_err,
  output logic                       busy,
  output logic                       err_sticky,
  input  logic                       err_clr
);
  localparam int BEATS      = LINE_BYTES * 8 / MEM_DATA_BITS;
  localparam int CW         = $clog2(BEATS) + 1;
  localparam int BEAT_SHIFT = $clog2(MEM_DATA_BITS / 8);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
  localparam logic [CW-1:0] ALL_BEATS  = CW'(BEATS);
  localparam logic [31:0]   LINE_MASK  = ~32'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, RESP} state_t;

  state_t                   state_reg, state_next;
  logic [31:0]              base_reg;
  logic [CW-1:0]            issue_cnt_reg, rcv_cnt_reg;
  logic [LINE_BYTES*8-1:0]  line_reg;
  logic                     accept, issue_fire, issue_last, resp_fire, rcv_last;
  logic [MEM_DATA_BITS-1:0] beat_word;

  assign accept     = (state_reg == IDLE) && miss_req_valid;
  assign issue_fire = (state_reg == FILL) && mem_req_ready;
  assign issue_last = issue_fire && (issue_cnt_reg == LAST_BEAT);
  // Responses only count while a line is in flight and never past the last beat.
  assign resp_fire  = ((state_reg == FILL) || (state_reg == DRAIN)) && mem_resp_valid &&
                      (rcv_cnt_reg != ALL_BEATS);
  assign rcv_last   = resp_fire && (rcv_cnt_reg == LAST_BEAT);
  assign beat_word  = mem_resp_err ? MEM_DATA_BITS'(ERR_WORD) : mem_resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    miss_req_ready  = 1'b0;
    miss_resp_valid = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    busy            = 1'b1;
    case (state_reg)
      IDLE: begin
        miss_req_ready = !rst;
        busy           = 1'b0;
        if (miss_req_valid) state_next = FILL;
      end
      FILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = base_reg + (32'(issue_cnt_reg) << BEAT_SHIFT);
        if (issue_last) state_next = rcv_last ? RESP : DRAIN;
      end
      DRAIN: begin
        if (rcv_last) state_next = RESP;
      end
      RESP: begin
        miss_resp_valid = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg      <= '0;
      issue_cnt_reg <= '0;
      rcv_cnt_reg   <= '0;
      line_reg      <= '0;
    end else if (accept) begin
      // Clearing the line on accept keeps stale words from a previous fill out of the result.
      base_reg      <= miss_req_addr & LINE_MASK;
      issue_cnt_reg <= '0;
      rcv_cnt_reg   <= '0;
      line_reg      <= '0;
    end else begin
      if (issue_fire) issue_cnt_reg <= issue_cnt_reg + CW'(1);
      if (resp_fire) begin
        rcv_cnt_reg <= rcv_cnt_reg + CW'(1);
        for (int i = 0; i < BEATS; i++) begin
          if (rcv_cnt_reg == CW'(i)) line_reg[i*MEM_DATA_BITS +: MEM_DATA_BITS] <= beat_word;
        end
      end
    end
  end

  // A new error on the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (resp_fire && mem_resp_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

  assign miss_resp_data = line_reg;

endmodule

// File: tb/tb_mcu_icache_refill.sv
// Directed bench for mcu_icache_refill: 8-beat instance with a behavioural memory
// (random stalls, delays, error injection) plus a 1-beat instance.
module tb_mcu_icache_refill;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         miss_req_valid = 1'b0;
  logic [31:0]  miss_req_addr  = '0;
  logic         miss_req_ready, miss_resp_valid;
  logic [255:0] miss_resp_data;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready  = 1'b1;
  logic         mem_resp_valid = 1'b0;
  logic [31:0]  mem_resp_data  = '0;
  logic         mem_resp_err   = 1'b0;
  logic         busy, err_sticky;
  logic         err_clr = 1'b0;

  logic         miss_req_valid1 = 1'b0;
  logic [31:0]  miss_req_addr1  = '0;
  logic         miss_req_ready1, miss_resp_valid1;
  logic [31:0]  miss_resp_data1;
  logic         mem_req_valid1;
  logic [31:0]  mem_req_addr1;
  logic         mem_req_ready1  = 1'b1;
  logic         mem_resp_valid1 = 1'b0;
  logic [31:0]  mem_resp_data1  = '0;
  logic         busy1, err_sticky1;

  mcu_icache_refill dut (
    .clk(clk), .rst(rst),
    .miss_req_valid(miss_req_valid), .miss_req_addr(miss_req_addr), .miss_req_ready(miss_req_ready),
    .miss_resp_valid(miss_resp_valid), .miss_resp_data(miss_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .busy(busy), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  mcu_icache_refill #(.LINE_BYTES(4)) dut1 (
    .clk(clk), .rst(rst),
    .miss_req_valid(miss_req_valid1), .miss_req_addr(miss_req_addr1), .miss_req_ready(miss_req_ready1),
    .miss_resp_valid(miss_resp_valid1), .miss_resp_data(miss_resp_data1),
    .mem_req_valid(mem_req_valid1), .mem_req_addr(mem_req_addr1), .mem_req_ready(mem_req_ready1),
    .mem_resp_valid(mem_resp_valid1), .mem_resp_data(mem_resp_data1), .mem_resp_err(1'b0),
    .busy(busy1), .err_sticky(err_sticky1), .err_clr(1'b0)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Memory model for the 8-beat instance: returns data = address, in order.
  bit          rand_ready = 1'b0;
  int          max_delay  = 1;
  int          err_beat   = -1;
  bit          spurious   = 1'b0;
  int          req_count  = 0;
  int          resp_count = 0;
  logic [31:0] req_log[$];
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          last_due = 0;
  int          m_due;
  logic [31:0] m_addr;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      last_due = 0;
    end else if (mem_req_valid && mem_req_ready) begin
      m_due = cyc + int'($urandom_range(1, max_delay)) - 1;
      if (m_due <= last_due) m_due = last_due + 1;
      q_addr.push_back(mem_req_addr);
      q_due.push_back(m_due);
      req_log.push_back(mem_req_addr);
      last_due = m_due;
      req_count++;
    end
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    mem_resp_data  = '0;
    mem_req_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (spurious) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_BEEF;
    end else if (!rst && q_due.size() > 0 && q_due[0] <= cyc) begin
      m_addr = q_addr.pop_front();
      void'(q_due.pop_front());
      mem_resp_valid = 1'b1;
      mem_resp_data  = m_addr;
      mem_resp_err   = (err_beat >= 0) && (m_addr[4:2] == 3'(err_beat));
      resp_count++;
    end
  end

  // Memory model for the 1-beat instance: always ready, 1-cycle read.
  bit          m1_fire;
  logic [31:0] m1_addr;
  int          req_count1 = 0;
  always @(posedge clk) begin
    m1_fire = mem_req_valid1 && mem_req_ready1;
    m1_addr = mem_req_addr1;
    if (m1_fire) req_count1++;
    #1;
    mem_resp_valid1 = m1_fire && !rst;
    mem_resp_data1  = m1_addr;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue_req(input logic [31:0] addr, input bit hold, output int t, output bit ok);
    bit go;
    ok = 1'b0;
    t  = 0;
    miss_req_addr  = addr;
    miss_req_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      go = miss_req_ready;
      tick();
      if (go) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    if (!hold) miss_req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (miss_resp_valid) begin
        ok = 1'b1;
        n  = cyc;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++; if (miss_req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_rst got=%0b want=0", miss_req_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b want=0", busy); end
    tests++; if (miss_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got=%0b want=0", miss_resp_valid); end
    tests++; if (miss_resp_data !== '0) begin fails++; $display("FAIL reset_resp_data got=%h want=0", miss_resp_data); end
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_req_valid got=%0b want=0", mem_req_valid); end
    tests++; if (mem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_req_addr got=%h want=0", mem_req_addr); end
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_err_sticky got=%0b want=0", err_sticky); end
    rst = 1'b0;
    #1;
    tests++; if (miss_req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after got=%0b want=1", miss_req_ready); end
    $display("[TB] reset checks done");
  endtask

  task automatic test_basic();
    int t, n;
    bit ok;
    logic [31:0] exp_w;
    req_log.delete();
    issue_req(32'h0000_104C, 1'b0, t, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_accept timeout"); end
    wait_resp(n, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_resp timeout"); end
    tests++; if (n + 1 != t + 10) begin fails++; $display("FAIL basic_latency got=T+%0d want=T+10", n + 1 - t); end
    for (int i = 0; i < 8; i++) begin
      exp_w = 32'h1040 + 32'(4 * i);
      tests++; if (miss_resp_data[i*32 +: 32] !== exp_w) begin fails++; $display("FAIL basic_word%0d got=%h want=%h", i, miss_resp_data[i*32 +: 32], exp_w); end
    end
    tests++; if (req_log.size() != 8) begin fails++; $display("FAIL basic_req_count got=%0d want=8", req_log.size()); end
    for (int i = 0; i < 8 && i < req_log.size(); i++) begin
      exp_w = 32'h1040 + 32'(4 * i);
      tests++; if (req_log[i] !== exp_w) begin fails++; $display("FAIL basic_req_addr%0d got=%h want=%h", i, req_log[i], exp_w); end
    end
    tick();
    tests++; if (miss_resp_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got=%0b want=0", miss_resp_valid); end
    tests++; if (busy !== 1'b0 || miss_req_ready !== 1'b1) begin fails++; $display("FAIL basic_back_idle busy=%0b ready=%0b want busy=0 ready=1", busy, miss_req_ready); end
    $display("[TB] basic fill 0x104C latency T+%0d", n + 1 - t);
  endtask

  task automatic test_stall();
    int t, pulses, hold_bad;
    bit ok, pv, pr;
    logic [31:0] pa, exp_w;
    rand_ready = 1'b1;
    max_delay  = 4;
    req_count  = 0;
    pulses     = 0;
    hold_bad   = 0;
    issue_req(32'h0000_104C, 1'b0, t, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stall_accept timeout"); end
    pv = 1'b0; pr = 1'b0; pa = '0;
    for (int k = 0; k < 400; k++) begin
      if (pv && !pr && mem_req_valid && mem_req_addr !== pa) hold_bad++;
      pv = mem_req_valid;
      pr = mem_req_ready;
      pa = mem_req_addr;
      if (miss_resp_valid) begin
        pulses++;
        for (int i = 0; i < 8; i++) begin
          exp_w = 32'h1040 + 32'(4 * i);
          tests++; if (miss_resp_data[i*32 +: 32] !== exp_w) begin fails++; $display("FAIL stall_word%0d got=%h want=%h", i, miss_resp_data[i*32 +: 32], exp_w); end
        end
      end
      if (pulses > 0 && !busy && k > 60) break;
      tick();
    end
    rand_ready = 1'b0;
    max_delay  = 1;
    tests++; if (hold_bad != 0) begin fails++; $display("FAIL stall_addr_hold changed=%0d want=0", hold_bad); end
    tests++; if (pulses != 1) begin fails++; $display("FAIL stall_pulses got=%0d want=1", pulses); end
    tests++; if (req_count != 8) begin fails++; $display("FAIL stall_req_count got=%0d want=8", req_count); end
    $display("[TB] stalled fill: %0d pulses, %0d requests", pulses, req_count);
  endtask

  task automatic test_error();
    int t, n;
    bit ok, done_clr;
    logic [31:0] exp_w;
    err_beat = 3;
    issue_req(32'h0000_104C, 1'b0, t, ok);
    wait_resp(n, ok);
    tests++; if (!ok) begin fails++; $display("FAIL err_resp timeout"); end
    for (int i = 0; i < 8; i++) begin
      exp_w = (i == 3) ? 32'h0010_0073 : 32'h1040 + 32'(4 * i);
      tests++; if (miss_resp_data[i*32 +: 32] !== exp_w) begin fails++; $display("FAIL err_word%0d got=%h want=%h", i, miss_resp_data[i*32 +: 32], exp_w); end
    end
    tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL err_sticky_set got=%0b want=1", err_sticky); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL err_clr got=%0b want=0", err_sticky); end
    issue_req(32'h0000_104C, 1'b0, t, ok);
    done_clr = 1'b0;
    for (int k = 0; k < 100 && !done_clr; k++) begin
      if (mem_resp_valid && mem_resp_err) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        done_clr = 1'b1;
        tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL err_set_wins got=%0b want=1", err_sticky); end
      end else begin
        tick();
      end
    end
    tests++; if (!done_clr) begin fails++; $display("FAIL err_second_error timeout"); end
    wait_resp(n, ok);
    err_beat = -1;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL err_final_clr got=%0b want=0", err_sticky); end
    $display("[TB] error beat 3 handled");
  endtask

  task automatic test_reset_mid();
    int t, n;
    bit ok;
    logic [31:0] exp_w;
    resp_count = 0;
    issue_req(32'h0000_104C, 1'b0, t, ok);
    for (int k = 0; k < 100 && resp_count < 4; k++) tick();
    tests++; if (resp_count < 4) begin fails++; $display("FAIL midrst_beats timeout got=%0d want=4", resp_count); end
    tick();
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || miss_req_ready !== 1'b0) begin fails++; $display("FAIL midrst_state busy=%0b ready=%0b want 0 0", busy, miss_req_ready); end
    tests++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin fails++; $display("FAIL midrst_mem valid=%0b addr=%h want 0 0", mem_req_valid, mem_req_addr); end
    tests++; if (miss_resp_valid !== 1'b0 || miss_resp_data !== '0) begin fails++; $display("FAIL midrst_resp valid=%0b data=%h want 0 0", miss_resp_valid, miss_resp_data); end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++; if (miss_req_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%0b want=1", miss_req_ready); end
    issue_req(32'h0000_2000, 1'b0, t, ok);
    wait_resp(n, ok);
    tests++; if (!ok) begin fails++; $display("FAIL midrst_resp timeout"); end
    for (int i = 0; i < 8; i++) begin
      exp_w = 32'h2000 + 32'(4 * i);
      tests++; if (miss_resp_data[i*32 +: 32] !== exp_w) begin fails++; $display("FAIL midrst_word%0d got=%h want=%h", i, miss_resp_data[i*32 +: 32], exp_w); end
    end
    tick();
    $display("[TB] reset mid-fill then fill 0x2000");
  endtask

  task automatic test_back_to_back();
    int t, n, ready_bad;
    bit ok;
    logic [31:0] exp_w;
    ready_bad = 0;
    issue_req(32'h0000_1000, 1'b1, t, ok);
    miss_req_addr = 32'h0000_5000;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (miss_req_ready !== 1'b0) ready_bad++;
      if (miss_resp_valid) ok = 1'b1;
      else tick();
    end
    tests++; if (!ok) begin fails++; $display("FAIL b2b_first_resp timeout"); end
    tests++; if (ready_bad != 0) begin fails++; $display("FAIL b2b_ready_low high_cycles=%0d want=0", ready_bad); end
    tests++; if (miss_resp_data[31:0] !== 32'h1000) begin fails++; $display("FAIL b2b_first_word got=%h want=00001000", miss_resp_data[31:0]); end
    tick();
    tests++; if (miss_req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_resp got=%0b want=1", miss_req_ready); end
    tick();
    miss_req_valid = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_second_accept busy=%0b want=1", busy); end
    wait_resp(n, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_second_resp timeout"); end
    for (int i = 0; i < 8; i++) begin
      exp_w = 32'h5000 + 32'(4 * i);
      tests++; if (miss_resp_data[i*32 +: 32] !== exp_w) begin fails++; $display("FAIL b2b_word%0d got=%h want=%h", i, miss_resp_data[i*32 +: 32], exp_w); end
    end
    tick();
    tick();
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    tick();
    tests++; if (busy !== 1'b0 || miss_req_ready !== 1'b1) begin fails++; $display("FAIL spurious_state busy=%0b ready=%0b want 0 1", busy, miss_req_ready); end
    tests++; if (miss_resp_data[31:0] !== 32'h5000) begin fails++; $display("FAIL spurious_data got=%h want=00005000", miss_resp_data[31:0]); end
    $display("[TB] back-to-back 0x1000 then 0x5000, spurious response ignored");
  endtask

  task automatic test_single_beat();
    int t, n;
    bit ok;
    tests++; if (miss_req_ready1 !== 1'b1) begin fails++; $display("FAIL single_ready got=%0b want=1", miss_req_ready1); end
    req_count1 = 0;
    miss_req_addr1  = 32'h0000_3007;
    miss_req_valid1 = 1'b1;
    tick();
    t = cyc;
    miss_req_valid1 = 1'b0;
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (miss_resp_valid1) begin ok = 1'b1; n = cyc; end
      else tick();
    end
    tests++; if (!ok) begin fails++; $display("FAIL single_resp timeout"); end
    tests++; if (n + 1 != t + 3) begin fails++; $display("FAIL single_latency got=T+%0d want=T+3", n + 1 - t); end
    tests++; if (miss_resp_data1 !== 32'h0000_3004) begin fails++; $display("FAIL single_data got=%h want=00003004", miss_resp_data1); end
    tests++; if (req_count1 != 1) begin fails++; $display("FAIL single_reads got=%0d want=1", req_count1); end
    tick();
    tests++; if (miss_resp_valid1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL single_idle valid=%0b busy=%0b want 0 0", miss_resp_valid1, busy1); end
    $display("[TB] single-beat line latency T+%0d", n + 1 - t);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
